// File: rtl/key_sched_pkg.sv
// Shared widths, FSM states and the command bundle for the key voice scheduler.
package key_sched_pkg;
  localparam int N_KEYS    = 4;
  localparam int N_VOICES  = 2;
  localparam int AGE_WIDTH = 4;
  localparam int KW = $clog2(N_KEYS);
  localparam int VW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    STEAL_OFF
  } state_t;

  typedef struct packed {
    logic          on;
    logic [VW-1:0] voice;
    logic [KW-1:0] key;
  } cmd_t;
endpackage

// File: rtl/voice_pick.sv
// Combinational voice selector: lowest free voice and oldest busy victim.
module voice_pick
  import key_sched_pkg::*;
#(
  parameter int NV = N_VOICES,
  parameter int AW = AGE_WIDTH
) (
  input  logic [NV-1:0]    busy,
  input  logic [NV*AW-1:0] age,
  output logic             any_free,
  output logic [VW-1:0]    free_v,
  output logic [VW-1:0]    victim_v
);
  logic [AW-1:0] best;

  always_comb begin
    any_free = 1'b0;
    free_v   = '0;
    victim_v = '0;
    best     = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_v   = VW'(i);
      end
    end
    // strict compare keeps the lowest index on an age tie
    for (int i = 0; i < NV; i++) begin
      if (age[i*AW +: AW] > best) begin
        best     = age[i*AW +: AW];
        victim_v = VW'(i);
      end
    end
  end
endmodule

// File: rtl/key_voice_scheduler.sv
// Key edge capture, voice allocation with oldest-voice stealing, and the
// note-on/note-off command handshake towards the tone engine.
module key_voice_scheduler
  import key_sched_pkg::*;
#(
  parameter int NUM_KEYS   = N_KEYS,
  parameter int NUM_VOICES = N_VOICES,
  parameter int AGE_W      = AGE_WIDTH
) (
  input  logic                     TP_DCLK,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      pianokey,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_on,
  output logic [VW-1:0]            cmd_voice,
  output logic [KW-1:0]            cmd_key,
  output logic [NUM_VOICES-1:0]    voice_busy,
  output logic [NUM_VOICES*KW-1:0] voice_key
);
  state_t state;
  cmd_t   cmd;

  logic [KW-1:0]            svc_key;
  logic                     svc_on;
  logic [NUM_KEYS-1:0]      key_q;
  logic [NUM_KEYS-1:0]      press_pend;
  logic [NUM_KEYS-1:0]      rel_pend;
  logic [NUM_VOICES-1:0]    busy;
  logic [NUM_VOICES*KW-1:0] vkey;
  logic [NUM_VOICES*AGE_W-1:0] age;

  logic [NUM_KEYS-1:0] rise, fall;
  logic [NUM_KEYS-1:0] clr_press, clr_rel, inflight;
  logic [NUM_KEYS-1:0] press_nx, rel_nx;
  logic                rel_any, press_any, hold_any;
  logic [KW-1:0]       rel_k, press_k;
  logic [VW-1:0]       hold_v;
  logic                any_free;
  logic [VW-1:0]       free_v, victim_v;

  voice_pick #(
    .NV(NUM_VOICES),
    .AW(AGE_W)
  ) u_pick (
    .busy    (busy),
    .age     (age),
    .any_free(any_free),
    .free_v  (free_v),
    .victim_v(victim_v)
  );

  assign rise = pianokey & ~key_q;
  assign fall = ~pianokey & key_q;

  always_comb begin
    rel_any   = 1'b0;
    rel_k     = '0;
    press_any = 1'b0;
    press_k   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rel_pend[i]) begin
        rel_any = 1'b1;
        rel_k   = KW'(i);
      end
      if (press_pend[i]) begin
        press_any = 1'b1;
        press_k   = KW'(i);
      end
    end
    hold_any = 1'b0;
    hold_v   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (busy[i] && vkey[i*KW +: KW] == rel_k) begin
        hold_any = 1'b1;
        hold_v   = VW'(i);
      end
    end
  end

  // A press already committed to a command cannot be cancelled by a
  // quick release; that release is queued as a normal note-off instead.
  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    inflight  = '0;
    unique case (state)
      IDLE: begin
        if (rel_any) begin
          if (!hold_any) clr_rel[rel_k] = 1'b1;
        end else if (press_any) begin
          inflight[press_k] = 1'b1;
        end
      end
      SEND: begin
        if (svc_on) inflight[svc_key] = 1'b1;
        if (cmd_ready) begin
          if (svc_on) clr_press[svc_key] = 1'b1;
          else        clr_rel[svc_key]   = 1'b1;
        end
      end
      STEAL_OFF: inflight[svc_key] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    press_nx = press_pend & ~clr_press;
    rel_nx   = rel_pend & ~clr_rel;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (rise[k]) press_nx[k] = 1'b1;
      if (fall[k]) begin
        if (press_pend[k] && !inflight[k]) press_nx[k] = 1'b0;
        else                               rel_nx[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge TP_DCLK) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      svc_key    <= '0;
      svc_on     <= 1'b0;
      key_q      <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      busy       <= '0;
      vkey       <= '0;
      age        <= '0;
    end else begin
      key_q      <= pianokey;
      press_pend <= press_nx;
      rel_pend   <= rel_nx;
      unique case (state)
        IDLE: begin
          if (rel_any) begin
            if (hold_any) begin
              cmd       <= '{on: 1'b0, voice: hold_v, key: rel_k};
              svc_key   <= rel_k;
              svc_on    <= 1'b0;
              cmd_valid <= 1'b1;
              state     <= SEND;
            end
          end else if (press_any) begin
            svc_key   <= press_k;
            svc_on    <= 1'b1;
            cmd_valid <= 1'b1;
            if (any_free) begin
              cmd   <= '{on: 1'b1, voice: free_v, key: press_k};
              state <= SEND;
            end else begin
              cmd   <= '{on: 1'b0, voice: victim_v,
                         key: vkey[victim_v*KW +: KW]};
              state <= STEAL_OFF;
            end
          end
        end
        SEND: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
            if (cmd.on) begin
              busy[cmd.voice]            <= 1'b1;
              vkey[cmd.voice*KW +: KW]   <= cmd.key;
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (VW'(i) == cmd.voice)
                  age[i*AGE_W +: AGE_W] <= '0;
                else if (busy[i] && age[i*AGE_W +: AGE_W] != {AGE_W{1'b1}})
                  age[i*AGE_W +: AGE_W] <= age[i*AGE_W +: AGE_W] + 1'b1;
              end
            end else begin
              busy[cmd.voice]                <= 1'b0;
              age[cmd.voice*AGE_W +: AGE_W]  <= '0;
            end
          end
        end
        STEAL_OFF: begin
          if (cmd_ready) begin
            cmd   <= '{on: 1'b1, voice: cmd.voice, key: svc_key};
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_on     = cmd.on;
  assign cmd_voice  = cmd.voice;
  assign cmd_key    = cmd.key;
  assign voice_busy = busy;
  assign voice_key  = vkey;
endmodule

// File: tb/tb_key_voice_scheduler.sv
// Bench for key_voice_scheduler: directed scenarios plus random key toggles
// checked against a voice-allocation model.
module tb_key_voice_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pianokey = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, cmd_on;
  logic [0:0] cmd_voice;
  logic [1:0] cmd_key;
  logic [1:0] voice_busy;
  logic [3:0] voice_key;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       on;
    logic       v;
    logic [1:0] k;
  } ecmd_t;

  ecmd_t q[$];
  bit    m_busy[2];
  int    m_key[2];
  int    m_age[2];

  key_voice_scheduler dut (
    .TP_DCLK   (clk),
    .rst       (rst),
    .pianokey  (pianokey),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_on    (cmd_on),
    .cmd_voice (cmd_voice),
    .cmd_key   (cmd_key),
    .voice_busy(voice_busy),
    .voice_key (voice_key)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ecmd_t mk(input bit on, input int v, input int k);
    ecmd_t e;
    e.on = on;
    e.v  = v[0];
    e.k  = k[1:0];
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_key[i]  = 0;
      m_age[i]  = 0;
    end
    q.delete();
  endfunction

  function automatic void model_press(input int k);
    int v = -1;
    for (int i = 0; i < 2; i++)
      if (!m_busy[i] && v < 0) v = i;
    if (v < 0) begin
      v = 0;
      for (int i = 1; i < 2; i++)
        if (m_age[i] > m_age[v]) v = i;
      q.push_back(mk(1'b0, v, m_key[v]));
    end
    q.push_back(mk(1'b1, v, k));
    for (int i = 0; i < 2; i++)
      if (i != v && m_busy[i]) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
    m_age[v]  = 0;
    m_busy[v] = 1;
    m_key[v]  = k;
  endfunction

  function automatic void model_release(input int k);
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] && m_key[i] == k) begin
        q.push_back(mk(1'b0, i, k));
        m_busy[i] = 0;
        m_age[i]  = 0;
        return;
      end
    end
  endfunction

  task automatic apply_edges(input logic [3:0] nk);
    logic [3:0] old = pianokey;
    pianokey = nk;
    for (int k = 0; k < 4; k++)
      if (old[k] && !nk[k]) model_release(k);
    for (int k = 0; k < 4; k++)
      if (!old[k] && nk[k]) model_press(k);
  endtask

  task automatic wait_valid(input string tag, input int max_wait);
    int w = 0;
    while (!cmd_valid && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  task automatic expect_cmd(input string tag, input ecmd_t e,
                            input int stall, input int max_wait);
    logic [3:0] snap;
    wait_valid(tag, max_wait);
    if (!cmd_valid) return;
    snap = {cmd_on, cmd_voice, cmd_key};
    chk({tag, "_cmd"}, 32'(snap), 32'(e));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stable"}, 32'({cmd_valid, cmd_on, cmd_voice, cmd_key}),
          32'({1'b1, snap}));
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    logic seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= cmd_valid;
    end
    chk({tag, "_idle"}, 32'(seen), 32'd0);
  endtask

  task automatic check_state(input string tag);
    logic [1:0] eb;
    logic [3:0] ek;
    for (int i = 0; i < 2; i++) begin
      eb[i]         = m_busy[i];
      ek[i*2 +: 2]  = m_key[i][1:0];
    end
    chk({tag, "_busy"}, 32'(voice_busy), 32'(eb));
    chk({tag, "_vkey"}, 32'(voice_key), 32'(ek));
  endtask

  task automatic drain(input string tag, input int smax);
    ecmd_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      expect_cmd(tag, e, int'($urandom_range(0, smax)), 20);
    end
    check_idle(tag);
    check_state(tag);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_fields"}, 32'({cmd_on, cmd_voice, cmd_key}), 32'd0);
    chk({tag, "_busy"}, 32'(voice_busy), 32'd0);
    chk({tag, "_vkey"}, 32'(voice_key), 32'd0);
  endtask

  initial begin
    ecmd_t      e;
    logic [3:0] snap;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // 1: latency with ready held high
    cmd_ready = 1'b1;
    apply_edges(4'b0100);
    e = q.pop_front();
    @(negedge clk);
    chk("lat_early", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(cmd_valid), 32'd1);
    chk("lat_cmd", 32'({cmd_on, cmd_voice, cmd_key}), 32'(e));
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("lat_drop", 32'(cmd_valid), 32'd0);
    check_state("t1");
    apply_edges(4'b0000);
    drain("t1_rel", 0);

    // 2: simultaneous presses, then releases
    apply_edges(4'b1001);
    drain("t2_on", 2);
    apply_edges(4'b1000);
    drain("t2_off0", 1);
    apply_edges(4'b0000);
    drain("t2_off3", 0);

    // 3: voice stealing and release of a stolen key
    apply_edges(4'b0001);
    drain("t3_k0", 0);
    apply_edges(4'b0011);
    drain("t3_k1", 0);
    apply_edges(4'b0111);
    drain("t3_steal", 2);
    apply_edges(4'b0110);
    drain("t3_rel0", 0);
    apply_edges(4'b0010);
    drain("t3_rel2", 0);
    apply_edges(4'b0000);
    drain("t3_rel1", 0);

    // 4: short tap while a command is stalled
    apply_edges(4'b1000);
    wait_valid("t4_wait", 20);
    pianokey[1] = 1'b1;
    @(negedge clk);
    pianokey[1] = 1'b0;
    repeat (2) @(negedge clk);
    drain("t4_tap", 0);
    apply_edges(4'b0000);
    drain("t4_rel", 0);

    // 5: long stall with a new edge queued behind it
    apply_edges(4'b0100);
    e = q.pop_front();
    wait_valid("t5", 20);
    snap = {cmd_on, cmd_voice, cmd_key};
    chk("t5_cmd", 32'(snap), 32'(e));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_hold", 32'({cmd_valid, cmd_on, cmd_voice, cmd_key}),
          32'({1'b1, snap}));
      if (i == 3) apply_edges(4'b1100);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    expect_cmd("t5_next", q.pop_front(), 0, 2);
    check_idle("t5");
    check_state("t5");
    apply_edges(4'b0000);
    drain("t5_rel", 1);

    // 6: reset while a steal note-off is pending
    apply_edges(4'b0001);
    drain("t6_k0", 0);
    apply_edges(4'b0101);
    drain("t6_k2", 0);
    apply_edges(4'b1101);
    e = q.pop_front();
    wait_valid("t6_steal", 20);
    chk("t6_off", 32'({cmd_on, cmd_voice, cmd_key}), 32'(e));
    rst = 1'b1;
    pianokey = '0;
    @(negedge clk);
    check_reset("t6_rst");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    apply_edges(4'b0010);
    drain("t6_k1", 0);
    apply_edges(4'b0000);
    drain("t6_rel", 0);

    // random key toggles with random engine stalls
    for (int it = 0; it < 80; it++) begin
      apply_edges(pianokey ^ 4'($urandom_range(1, 15)));
      drain("rnd", 3);
    end
    apply_edges(4'b0000);
    drain("rnd_end", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
